debounce_multi: RTL and testbench



---
 rtl/debounce_multi.sv | 148 ++++++++++++++
 tb/tb_debounce_multi.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: multi-channel push-button / switch debouncer.
//   Each channel is synchronised to clk, sampled on the one-cycle tick strobe,
//   and a new level is accepted only after STABLE_TICKS consecutive samples
//   that disagree with the current level. Optional auto-repeat on held
//   buttons is built when DEBOUNCE_AUTOREPEAT_EN is defined.
// Ports:
//   clk    - system clock (sole clock)
//   rst_n  - asynchronous active-low reset
//   tick   - sample enable, high for one clk per sample period
//   in     - raw asynchronous inputs, one bit per channel
//   level  - debounced level per channel (registered)
//   rise   - one-clk pulse on accepted 0->1, plus auto-repeats if built (registered)
//   fall   - one-clk pulse on accepted 1->0 (registered)
module debounce_multi #(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned STABLE_TICKS = 4,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned REPEAT_DELAY = 50,
   parameter int unsigned REPEAT_RATE  = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);

   localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);

`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
`else
   // Repeat parameters have no effect in this build.
   logic cfg_unused_c;
   assign cfg_unused_c = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [CNT_W-1:0]       cnt_q;
      logic [CNT_W-1:0]       cnt_d;
      logic                   level_q;
      logic                   level_d;
      logic                   rise_q;
      logic                   rise_d;
      logic                   fall_q;
      logic                   fall_d;
      logic                   s_c;
      logic                   accept_c;
      logic                   rep_fire_c;

      assign s_c = sync_q[SYNC_STAGES-1];

      // Synchroniser chain, clocked every cycle regardless of tick.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync_q <= '0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in[i]};
         end
      end

      // Stability counter: counts consecutive ticks disagreeing with level.
      always_comb begin
         cnt_d    = cnt_q;
         level_d  = level_q;
         accept_c = 1'b0;
         if (tick) begin
            if (s_c == level_q) begin
               cnt_d = '0;
            end else if (cnt_q + CNT_W'(1) == CNT_W'(STABLE_TICKS)) begin
               accept_c = 1'b1;
               level_d  = s_c;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end

      // Repeat fires only while level is high and not being accepted low,
      // so rise and fall can never coincide.
      assign rise_d = (accept_c & s_c) | rep_fire_c;
      assign fall_d = accept_c & ~s_c;

`ifdef DEBOUNCE_AUTOREPEAT_EN
      logic [REP_W-1:0] rep_cnt_q;
      logic [REP_W-1:0] rep_cnt_d;
      logic             rep_phase_q;
      logic             rep_phase_d;

      // Held-button repeat: first interval REPEAT_DELAY, then REPEAT_RATE.
      always_comb begin
         rep_cnt_d   = rep_cnt_q;
         rep_phase_d = rep_phase_q;
         rep_fire_c  = 1'b0;
         if (!level_q || accept_c) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
         end else if (tick) begin
            if (rep_cnt_q + REP_W'(1) ==
                (rep_phase_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DELAY))) begin
               rep_fire_c  = 1'b1;
               rep_cnt_d   = '0;
               rep_phase_d = 1'b1;
            end else begin
               rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
         end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
         end
      end
`else
      assign rep_fire_c = 1'b0;
`endif

      // Channel state and registered pulses.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
         end
      end

      assign level[i] = level_q;
      assign rise[i]  = rise_q;
      assign fall[i]  = fall_q;
   end

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed scenarios plus randomized stimulus for
// debounce_multi, checked every cycle against a sample-history reference model.
`timescale 1ns/1ps
module tb_debounce_multi;

   localparam int unsigned CH    = 4;
   localparam int unsigned ST    = 4;
   localparam int unsigned SYNC  = 2;
   localparam int unsigned RDLY  = 5;
   localparam int unsigned RRATE = 2;
   localparam logic [31:0] MASK  = (32'd1 << ST) - 32'd1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          tick;
   logic [CH-1:0] in;
   logic [CH-1:0] level;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;

   int n_cmp = 0;
   int n_err = 0;

   debounce_multi #(
      .CHANNELS    (CH),
      .STABLE_TICKS(ST),
      .SYNC_STAGES (SYNC),
      .REPEAT_DELAY(RDLY),
      .REPEAT_RATE (RRATE)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick),
      .in   (in),
      .level(level),
      .rise (rise),
      .fall (fall)
   );

   always #5 clk = ~clk;

   // Reference model: input delay line, per-channel tick-sample history,
   // ticks held high since acceptance.
   logic [CH-1:0] dq[$];
   logic [31:0]   hist [CH];
   int            nsamp [CH];
   int            held [CH];
   logic [CH-1:0] m_level;
   logic [CH-1:0] m_rise;
   logic [CH-1:0] m_fall;
   int            tick_mode;
   int            tcnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      dq.delete();
      for (int k = 0; k < int'(SYNC); k++) dq.push_back('0);
      for (int c = 0; c < int'(CH); c++) begin
         hist[c]  = '0;
         nsamp[c] = 0;
         held[c]  = 0;
      end
      m_level = '0;
      m_rise  = '0;
      m_fall  = '0;
   endfunction

   // Accept when the last ST tick samples all disagree with the current level.
   function automatic void model_edge(input logic t, input logic [CH-1:0] din);
      logic [CH-1:0] s;
      s = dq.pop_front();
      dq.push_back(din);
      m_rise = '0;
      m_fall = '0;
      if (t) begin
         for (int c = 0; c < int'(CH); c++) begin
            hist[c] = {hist[c][30:0], s[c]};
            nsamp[c]++;
            if (nsamp[c] >= int'(ST) && (hist[c] & MASK) == (m_level[c] ? 32'd0 : MASK)) begin
               nsamp[c] = 0;
               if (m_level[c]) m_fall[c] = 1'b1;
               else begin
                  m_rise[c] = 1'b1;
                  held[c]   = 0;
               end
               m_level[c] = ~m_level[c];
            end else if (m_level[c]) begin
               held[c]++;
`ifdef DEBOUNCE_AUTOREPEAT_EN
               if (held[c] == int'(RDLY) ||
                   (held[c] > int'(RDLY) && (held[c] - int'(RDLY)) % int'(RRATE) == 0))
                  m_rise[c] = 1'b1;
`endif
            end
         end
      end
   endfunction

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_edge(tick, in);
      @(negedge clk);
      check("level", 32'(level), 32'(m_level));
      check("rise",  32'(rise),  32'(m_rise));
      check("fall",  32'(fall),  32'(m_fall));
      case (tick_mode)
         0: begin
            tcnt = (tcnt + 1) % 8;
            tick = (tcnt == 7);
         end
         1: tick = 1'b1;
         default: tick = ($urandom_range(0, 2) == 0);
      endcase
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   // Asserted and released at a negedge; outputs must clear immediately.
   task automatic do_reset(input int hold);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("rst_level", 32'(level), 32'd0);
      check("rst_pulse", 32'(rise | fall), 32'd0);
      run(hold);
      rst_n = 1'b1;
      #1;
      check("rel_level", 32'(level), 32'd0);
      check("rel_pulse", 32'(rise | fall), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      tick      = 1'b0;
      in        = 4'hF;
      tick_mode = 0;
      tcnt      = 0;
      model_reset();
      @(negedge clk);
      // Reset with all inputs high, then accept them through the counter.
      do_reset(3);
      run(8 * 6 + 4);
      check("all_high", 32'(level), 32'hF);
      // Clean press on channel 1 only.
      in = 4'h0;
      run(8 * 7);
      in[1] = 1'b1;
      run(8 * 6);
      check("press1", 32'(level), 32'h2);
      // Bounce: 3 high, 1 low, then stable; then a 2-tick low glitch.
      in[0] = 1'b1; run(8 * 3);
      in[0] = 1'b0; run(8);
      in[0] = 1'b1; run(8 * 6);
      in[0] = 1'b0; run(16);
      in[0] = 1'b1; run(8 * 3);
      check("bounce", 32'(level), 32'h3);
      // Simultaneous release and press on different channels.
      in[2] = 1'b1;
      run(8 * 6);
      in = 4'b1000;
      run(8 * 7);
      check("indep", 32'(level), 32'h8);
      // Reset in the middle of a count.
      in = 4'h0;
      run(8 * 7);
      in[0] = 1'b1;
      run(16);
      do_reset(2);
      run(8 * 6);
      check("mid_rst", 32'(level), 32'h1);
      // Long hold then release (exercises auto-repeat when built).
      in[0] = 1'b0; run(8 * 7);
      in[0] = 1'b1; run(8 * 15);
      in[0] = 1'b0; run(8 * 8);
      check("release", 32'(level), 32'h0);
      // Randomized phases: tick modes, bounce densities, sporadic resets.
      for (int p = 0; p < 8; p++) begin
         tick_mode = p % 3;
         for (int k = 0; k < 400; k++) begin
            int unsigned odds;
            odds = (p % 2 == 0) ? 6 : 80;
            for (int b = 0; b < int'(CH); b++)
               if ($urandom_range(0, odds - 1) == 0) in[b] = ~in[b];
            if ($urandom_range(0, 999) == 0) do_reset(int'($urandom_range(1, 3)));
            cycle();
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
